// File: rtl/riscv_fetch_pkg.sv
// Shared types for the instruction fetch front end:
// queue entry layout, fetch FSM states, canonical NOP.
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Fetch-unit bus bundle: imem req/gnt + rvalid side and
// core valid/ready side. master = fetch unit, slave = env.
interface inst_prefetch_queue_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata,
    output inst,
    output inst_pc,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata,
    input  inst,
    input  inst_pc,
    input  inst_valid,
    output inst_ready
  );

endinterface

// File: rtl/inst_prefetch_queue_fifo.sv
// sync_fifo: register-based in-order FIFO, push/pop/flush,
// full/empty/count. Ports: clk, rst, push, pop, flush, wdata, rdata.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // a pop frees the slot a same-cycle push needs
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Fetch front end: issues sequential imem fetches, queues {pc,inst}.
// Ports: clk, rst, redirect, redirect_pc, bus (master: imem + core).
module inst_prefetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  redirect,
  input logic [31:0]           redirect_pc,
  inst_prefetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic          rst_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   fetch_pc_d;
  logic [OW-1:0] outst_q;
  logic [OW-1:0] outst_d;
  logic [OW-1:0] discard_q;
  logic [OW-1:0] discard_d;
  logic [OW-1:0] left;

  logic          issue;
  logic          rv;
  logic          keep;
  logic          q_pop;
  logic          q_empty;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_wdata;
  fetch_entry_t  q_head;
  logic [31:0]   tag_pc;

  logic          unused_q_full;
  logic          unused_tag_full;
  logic          unused_tag_empty;
  logic [OW-1:0] unused_tag_count;

  // slots already promised to in-flight fetches count as used
  assign bus.mem_req = !rst_q && !redirect
    && ((int'(q_count) + int'(outst_q)) < DEPTH)
    && (int'(outst_q) < MAX_OUTST);
  assign bus.mem_addr = fetch_pc_q;

  assign issue = bus.mem_req && bus.mem_gnt;
  assign rv    = bus.mem_rvalid && (outst_q != '0);
  assign keep  = rv && (discard_q == '0) && !redirect;
  assign q_pop = bus.inst_valid && bus.inst_ready
    && !redirect;
  assign left  = outst_q - OW'(rv);

  assign q_wdata.pc   = tag_pc;
  assign q_wdata.inst = bus.mem_rdata;

  assign bus.inst_valid = !q_empty;
  assign bus.inst    = q_empty ? '0 : q_head.inst;
  assign bus.inst_pc = q_empty ? '0 : q_head.pc;

  sync_fifo #(
    .WIDTH(64),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .push (keep),
    .pop  (q_pop),
    .flush(redirect),
    .wdata(q_wdata),
    .rdata(q_head),
    .full (unused_q_full),
    .empty(q_empty),
    .count(q_count)
  );

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(MAX_OUTST)
  ) u_tags (
    .clk  (clk),
    .rst  (rst),
    .push (issue),
    .pop  (keep),
    .flush(redirect),
    .wdata(fetch_pc_q),
    .rdata(tag_pc),
    .full (unused_tag_full),
    .empty(unused_tag_empty),
    .count(unused_tag_count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  assign outst_d = outst_q + OW'(issue) - OW'(rv);

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          discard_d = left;
          state_d   = (left != '0) ? DISCARD : FETCH;
        end
      end
      DISCARD: begin
        if (redirect) begin
          discard_d = left;
          state_d   = (left != '0) ? DISCARD : FETCH;
        end else if (rv) begin
          discard_d = discard_q - 1'b1;
          if (discard_d == '0) begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q      <= 1'b1;
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      rst_q      <= 1'b0;
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  a_no_spurious_rvalid: assert property (
    @(posedge clk) disable iff (rst)
      !(bus.mem_rvalid && (outst_q == '0))
  );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed table, corner
// sequences and random traffic against a queue/epoch model.
module tb_inst_prefetch_queue;
  import riscv_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  inst_prefetch_queue_if bus();

  inst_prefetch_queue #(
    .DEPTH(DEPTH),
    .MAX_OUTST(MAX_OUTST),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  typedef struct {
    bit          ready;
    bit          gnt;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  req_t        pend[$];
  logic [31:0] buffer[$];
  int          epoch = 0;
  int          cyc = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [31:0] exp_issue = RESET_PC;
  logic [31:0] exp_deliver = RESET_PC;
  bit          rst_q_m = 1'b1;

  int n_tests = 0;
  int n_fail = 0;

  logic        o_req, o_valid, o_fire, o_hs;
  logic [31:0] o_addr, o_pc, o_inst;

  function automatic logic [31:0] word_of(
    input logic [31:0] a
  );
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk32(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name,
                      input logic act,
                      input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance
  // the model to the state after the following posedge.
  task automatic step(input bit rs, input bit rdy,
                      input bit gnt, input bit rdr,
                      input logic [31:0] rpc);
    bit          rv;
    bit          exp_req;
    bit          have;
    logic [31:0] exp_pc;
    req_t        e;
    @(negedge clk);
    rst = rs;
    rv = !rs && pend.size() > 0 && pend[0].due <= cyc;
    bus.mem_rvalid = rv;
    bus.mem_rdata = rv ? word_of(pend[0].addr) : 32'h0;
    bus.mem_gnt = gnt;
    bus.inst_ready = rdy;
    redirect = rdr;
    redirect_pc = rpc;
    #1;
    o_req = bus.mem_req;
    o_addr = bus.mem_addr;
    o_valid = bus.inst_valid;
    o_pc = bus.inst_pc;
    o_inst = bus.inst;
    have = buffer.size() > 0;
    exp_pc = have ? buffer[0] : 32'h0;
    exp_req = !rst_q_m && !rdr
      && (buffer.size() + pend.size() < DEPTH)
      && (pend.size() < MAX_OUTST);
    chk1("mem_req", o_req, exp_req);
    if (exp_req) chk32("mem_addr", o_addr, exp_issue);
    chk1("inst_valid", o_valid, have);
    chk32("inst_pc", o_pc, exp_pc);
    chk32("inst", o_inst, have ? word_of(exp_pc) : 32'h0);
    o_fire = o_req && gnt;
    o_hs = o_valid && rdy && !rdr && !rs;
    if (rs) begin
      pend.delete();
      buffer.delete();
      epoch++;
      exp_issue = RESET_PC;
      exp_deliver = RESET_PC;
    end else if (rdr) begin
      buffer.delete();
      epoch++;
      exp_issue = rpc & ~32'h3;
      exp_deliver = exp_issue;
      if (rv) e = pend.pop_front();
    end else begin
      if (o_hs) begin
        chk32("deliver_pc", o_pc, exp_deliver);
        exp_deliver += 32'd4;
        if (have) void'(buffer.pop_front());
      end
      if (rv) begin
        e = pend.pop_front();
        if (e.epoch == epoch) buffer.push_back(e.addr);
      end
      if (o_fire) begin
        e.addr = o_addr;
        e.due = cyc + int'($urandom_range(lat_hi, lat_lo));
        e.epoch = epoch;
        pend.push_back(e);
        exp_issue += 32'd4;
      end
    end
    rst_q_m = rs;
    cyc++;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[6];
    logic [31:0] fires[$];
    logic [31:0] dels[$];
    int          n;
    bit          found;

    bus.mem_gnt = 0;
    bus.mem_rvalid = 0;
    bus.mem_rdata = 0;
    bus.inst_ready = 0;

    // 1: reset then gnt=1, latency 1, ready=1
    tv[0] = '{1, 1, 0, 32'h0, 0, 32'h0};
    tv[1] = '{1, 1, 1, 32'h0, 0, 32'h0};
    tv[2] = '{1, 1, 1, 32'h4, 0, 32'h0};
    tv[3] = '{1, 1, 1, 32'h8, 1, 32'h0};
    tv[4] = '{1, 1, 1, 32'hC, 1, 32'h4};
    tv[5] = '{1, 1, 1, 32'h10, 1, 32'h8};
    lat_lo = 1;
    lat_hi = 1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, tv[i].ready, tv[i].gnt, 0, 32'h0);
      chk1("t1_req", o_req, tv[i].req);
      chk32("t1_addr", o_addr, tv[i].addr);
      chk1("t1_valid", o_valid, tv[i].valid);
      chk32("t1_pc", o_pc, tv[i].pc);
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 0, 32'h0);
      if (o_hs) n++;
    end
    chk32("t1_steady", n, 8);

    // 2: ready=0 fills exactly DEPTH, then drains
    do_reset();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 0, 32'h0);
      if (o_fire) n++;
    end
    chk32("t2_grants", n, DEPTH);
    chk1("t2_req_low", o_req, 1'b0);
    chk32("t2_head", o_pc, 32'h0);
    fires.delete();
    dels.delete();
    for (int i = 0; i < 30 && dels.size() < 5; i++) begin
      step(0, 1, 1, 0, 32'h0);
      if (o_hs) dels.push_back(o_pc);
      if (o_fire) fires.push_back(o_addr);
    end
    chk32("t2_ndel", dels.size(), 5);
    for (int i = 0; i < 5 && i < dels.size(); i++)
      chk32("t2_del", dels[i], 32'(i * 4));
    chk1("t2_fired", fires.size() > 0, 1'b1);
    if (fires.size() > 0) chk32("t2_resume", fires[0], 32'h10);

    // 3: two outstanding at latency 3, redirect to 0x100
    lat_lo = 3;
    lat_hi = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pend.size() == 2 && buffer.size() > 0) found = 1;
      else step(0, 0, 1, 0, 32'h0);
    end
    chk1("t3_setup", found, 1'b1);
    step(0, 0, 1, 1, 32'h100);
    step(0, 1, 1, 0, 32'h0);
    chk1("t3_empty", o_valid, 1'b0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 1, 1, 0, 32'h0);
      if (o_hs) found = 1;
    end
    chk1("t3_got", found, 1'b1);
    if (found) chk32("t3_first_pc", o_pc, 32'h100);

    // 4: redirect with rvalid and pop in the same cycle
    lat_lo = 2;
    lat_hi = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pend.size() == 2 && pend[0].due <= cyc
          && buffer.size() > 0) begin
        found = 1;
        step(0, 1, 1, 1, 32'h200);
        chk1("t4_popped_valid", o_valid, 1'b1);
      end else begin
        step(0, 0, 1, 0, 32'h0);
      end
    end
    chk1("t4_setup", found, 1'b1);
    step(0, 1, 1, 0, 32'h0);
    chk1("t4_empty", o_valid, 1'b0);
    found = o_hs;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 1, 1, 0, 32'h0);
      if (o_hs) found = 1;
    end
    chk1("t4_got", found, 1'b1);
    if (found) chk32("t4_first_pc", o_pc, 32'h200);

    // 5: unaligned redirect near the top, address wrap
    lat_lo = 1;
    lat_hi = 1;
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 32'h0);
    step(0, 1, 1, 1, 32'hFFFF_FFFE);
    fires.delete();
    dels.delete();
    for (int i = 0; i < 20 && dels.size() < 2; i++) begin
      step(0, 1, 1, 0, 32'h0);
      if (o_fire) fires.push_back(o_addr);
      if (o_hs) dels.push_back(o_pc);
    end
    chk32("t5_nfire", fires.size() >= 2, 1);
    chk32("t5_ndel", dels.size(), 2);
    if (fires.size() >= 2) begin
      chk32("t5_fire0", fires[0], 32'hFFFF_FFFC);
      chk32("t5_fire1", fires[1], 32'h0);
    end
    if (dels.size() >= 2) begin
      chk32("t5_del0", dels[0], 32'hFFFF_FFFC);
      chk32("t5_del1", dels[1], 32'h0);
    end

    // 6: reset with full queue (incl. reservations)
    lat_lo = 3;
    lat_hi = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pend.size() == 2 && buffer.size() == 2) found = 1;
      else step(0, 0, 1, 0, 32'h0);
    end
    chk1("t6_setup", found, 1'b1);
    step(1, 0, 1, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0);
    chk1("t6_valid", o_valid, 1'b0);
    chk1("t6_req", o_req, 1'b0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 1, 1, 0, 32'h0);
      if (o_fire) found = 1;
    end
    chk1("t6_fired", found, 1'b1);
    if (found) chk32("t6_addr", o_addr, RESET_PC);

    // random traffic
    lat_lo = 1;
    lat_hi = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 600) == 0,
           ($urandom % 4) != 0,
           ($urandom % 3) != 0,
           ($urandom % 40) == 0,
           $urandom);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
